// File: rtl/icache_ctrl_if.sv
// icache_ctrl_if: fetch-side and refill-side signals of the instruction cache.
// slave is the cache's view; master is the view of the control unit plus memory.
interface icache_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  icache_req;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  icache_ready;
  logic [31:0]           icache_instr;
  logic                  invalidate;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;

  modport slave (
    input  icache_req, pc, invalidate, mem_ack, mem_rdata,
    output icache_ready, icache_instr, mem_req, mem_addr, hit_count, miss_count
  );

  modport master (
    output icache_req, pc, invalidate, mem_ack, mem_rdata,
    input  icache_ready, icache_instr, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped, read-only instruction cache. Hits answer one cycle
// after the request; misses refill the whole line word by word over mem_req/mem_ack.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic         clk,
  input  logic         reset,
  icache_ctrl_if.slave bus
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_LINES);
  localparam int WW = ADDR_WIDTH - 2;
  localparam int TW = WW - OB - IB;
  localparam logic [OB-1:0] LAST_WORD = OB'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_e;

  state_e                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [OB-1:0]          cnt_q, cnt_d;
  logic                   mem_req_q, mem_req_d;
  logic                   ready_q, ready_d;
  logic [31:0]            instr_q, instr_d;
  logic                   inv_pend_q, inv_pend_d;
  logic [WW-1:0]          word_q, word_d;

  logic [TW-1:0]          tag_q  [NUM_LINES];
  logic [31:0]            data_q [NUM_LINES][LINE_WORDS];

  logic [OB-1:0]          pc_off, fill_off;
  logic [IB-1:0]          pc_idx, fill_idx;
  logic [TW-1:0]          pc_tag, fill_tag;
  logic                   hit, fill_we, last_ack;

  // Address split of the live pc and of the latched miss address, plus hit detect.
  always_comb begin
    pc_off   = bus.pc[2 +: OB];
    pc_idx   = bus.pc[2+OB +: IB];
    pc_tag   = bus.pc[ADDR_WIDTH-1 -: TW];
    fill_off = word_q[0 +: OB];
    fill_idx = word_q[OB +: IB];
    fill_tag = word_q[WW-1 -: TW];
    // A same-edge invalidate wins over the lookup, so it forces a miss.
    hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && !bus.invalidate;
    fill_we  = (state_q == REFILL) && bus.mem_ack;
    last_ack = fill_we && (cnt_q == LAST_WORD);
  end

  // Next-state and next-output computation for the IDLE/REFILL/RESPOND controller.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    ready_d    = 1'b0;
    instr_d    = instr_q;
    inv_pend_d = inv_pend_q;
    word_d     = word_q;
    case (state_q)
      IDLE: begin
        if (bus.invalidate) valid_d = '0;
        if (bus.icache_req) begin
          if (hit) begin
            instr_d = data_q[pc_idx][pc_off];
            ready_d = 1'b1;
          end else begin
            word_d    = bus.pc[ADDR_WIDTH-1:2];
            cnt_d     = '0;
            mem_req_d = 1'b1;
            state_d   = REFILL;
          end
        end
      end
      REFILL: begin
        inv_pend_d = inv_pend_q | bus.invalidate;
        if (fill_we) begin
          cnt_d = cnt_q + OB'(1);
          if (last_ack) begin
            // A line whose refill overlapped an invalidate is kept but not trusted.
            valid_d[fill_idx] = !(inv_pend_q | bus.invalidate);
            mem_req_d         = 1'b0;
            state_d           = RESPOND;
          end
        end
      end
      RESPOND: begin
        instr_d    = data_q[fill_idx][fill_off];
        ready_d    = 1'b1;
        state_d    = IDLE;
        if (inv_pend_q || bus.invalidate) valid_d = '0;
        inv_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state and registered outputs, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      ready_q    <= 1'b0;
      instr_q    <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      ready_q    <= ready_d;
      instr_q    <= instr_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  // Tag/data storage and the latched miss address; meaningful only behind valid bits.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (fill_we) data_q[fill_idx][cnt_q] <= bus.mem_rdata;
    if (last_ack) tag_q[fill_idx] <= fill_tag;
  end

  assign bus.icache_ready = ready_q;
  assign bus.icache_instr = instr_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = {word_q[WW-1:OB], cnt_q, 2'b00};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Hits counted per hit-path response, misses per REFILL entry; both wrap.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == IDLE) && bus.icache_req) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed and randomized fetches against a line-residency model
// of the cache; memory contents are a fixed function of the word address.
module tb_icache_ctrl;
  localparam int ADDR_WIDTH = 32;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 16;
  localparam int OB         = $clog2(LINE_WORDS);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  icache_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  logic        ack_m     = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] rdata_m   = '0;
  assign bus.mem_ack   = ack_m | stray_ack;
  assign bus.mem_rdata = rdata_m;

  int checks = 0;
  int passes = 0;
  int lat    = 1;
  logic [31:0] exp_base = '0;

  // Model: which line address each index currently holds, plus statistics.
  int resident [int];
  int m_hits = 0;
  int m_miss = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Word-serial memory: acks every lat cycles while mem_req is high.
  initial begin : mem_model
    int wait_c;
    int k;
    wait_c = 0;
    k = 0;
    forever begin
      @(negedge clk);
      ack_m = 1'b0;
      if (reset === 1'b1 && bus.mem_req === 1'b1) begin
        check("mem_addr", bus.mem_addr, exp_base + 32'(4 * k));
        wait_c++;
        if (wait_c >= lat) begin
          ack_m   = 1'b1;
          rdata_m = mem_word(bus.mem_addr);
          wait_c  = 0;
          k++;
        end
      end else begin
        wait_c = 0;
        k = 0;
      end
    end
  end

  task automatic check_stats(input string tag);
    logic [31:0] eh, em;
`ifdef ICACHE_STATS_EN
    eh = 32'(m_hits);
    em = 32'(m_miss);
`else
    eh = '0;
    em = '0;
`endif
    check({tag, "_hits"}, bus.hit_count, eh);
    check({tag, "_miss"}, bus.miss_count, em);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.icache_req = 1'b0;
    bus.invalidate = 1'b0;
    bus.pc = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.icache_ready}, 32'd0);
    check("rst_instr", bus.icache_instr, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    resident.delete();
    m_hits = 0;
    m_miss = 0;
    check_stats("rst");
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic inval_idle();
    @(negedge clk);
    bus.invalidate = 1'b1;
    @(negedge clk);
    bus.invalidate = 1'b0;
    resident.delete();
  endtask

  // One fetch: optional invalidate on the request edge, at cycle inv_at of the
  // refill (0 = never), and repeated req pulses while the cache is busy.
  task automatic fetch(input logic [31:0] a, input bit inv_same, input int inv_at,
                       input bit stray);
    int line, idx, cyc, exp_cyc;
    bit exp_hit, saw_req, inv_mid;
    line = int'(a >> (2 + OB));
    idx  = line % NUM_LINES;
    @(negedge clk);
    bus.pc = a;
    bus.icache_req = 1'b1;
    bus.invalidate = inv_same;
    exp_base = (a >> (2 + OB)) << (2 + OB);
    if (inv_same) resident.delete();
    exp_hit = resident.exists(idx) && (resident[idx] == line);
    exp_cyc = exp_hit ? 1 : LINE_WORDS * lat + 2;
    @(posedge clk);
    #1;
    bus.icache_req = 1'b0;
    bus.invalidate = 1'b0;
    cyc = 0;
    saw_req = 1'b0;
    inv_mid = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.icache_req = 1'b0;
      bus.invalidate = 1'b0;
      if (bus.mem_req === 1'b1) saw_req = 1'b1;
      if (bus.icache_ready === 1'b1) break;
      if (cyc == inv_at) begin
        bus.invalidate = 1'b1;
        inv_mid = 1'b1;
      end
      if (stray) bus.icache_req = 1'b1;
    end
    check("ready_latency", 32'(cyc), 32'(exp_cyc));
    check("mem_req_seen", {31'd0, saw_req}, {31'd0, !exp_hit});
    check("instr", bus.icache_instr, mem_word(a & ~32'd3));
    @(negedge clk);
    check("ready_pulse", {31'd0, bus.icache_ready}, 32'd0);
    if (exp_hit) m_hits++;
    else begin
      m_miss++;
      if (inv_mid) resident.delete();
      else resident[idx] = line;
    end
  endtask

  initial begin : main
    int acks;
    logic [31:0] a;
    do_reset();

    // Cold miss, then hit in the same line.
    lat = 1;
    fetch(32'h100, 1'b0, 0, 1'b0);
    fetch(32'h108, 1'b0, 0, 1'b0);
    // Conflicting lines on one index.
    fetch(32'h500, 1'b0, 0, 1'b0);
    fetch(32'h100, 1'b0, 0, 1'b0);
    // Invalidate during refill: response correct, line not retained.
    fetch(32'h204, 1'b0, 2, 1'b0);
    fetch(32'h200, 1'b0, 0, 1'b0);
    fetch(32'h20C, 1'b0, 0, 1'b0);
    // Invalidate while idle, and on the same edge as a request.
    inval_idle();
    fetch(32'h20C, 1'b0, 0, 1'b0);
    fetch(32'h208, 1'b1, 0, 1'b0);
    fetch(32'h200, 1'b0, 0, 1'b0);
    // Slower memory with stray requests while busy.
    lat = 3;
    fetch(32'h3F0, 1'b0, 0, 1'b1);
    fetch(32'h3F4, 1'b0, 0, 1'b1);
    check_stats("directed");

    // Reset after the second ack of a refill.
    lat = 1;
    @(negedge clk);
    bus.pc = 32'h740;
    bus.icache_req = 1'b1;
    exp_base = 32'h740;
    @(posedge clk);
    #1;
    bus.icache_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 50 && acks < 2; i++) begin
      @(posedge clk);
      if (bus.mem_ack === 1'b1) acks++;
    end
    check("acks_before_reset", 32'(acks), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("midrst_ready", {31'd0, bus.icache_ready}, 32'd0);
    resident.delete();
    m_hits = 0;
    m_miss = 0;
    check_stats("midrst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    // A late ack while idle must be ignored.
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    fetch(32'h748, 1'b0, 0, 1'b0);
    fetch(32'h740, 1'b0, 0, 1'b0);
    check_stats("after_rst");

    // Statistics: 3 misses and 5 hits from a clean start.
    do_reset();
    fetch(32'h000, 1'b0, 0, 1'b0);
    fetch(32'h010, 1'b0, 0, 1'b0);
    fetch(32'h020, 1'b0, 0, 1'b0);
    fetch(32'h004, 1'b0, 0, 1'b0);
    fetch(32'h008, 1'b0, 0, 1'b0);
    fetch(32'h014, 1'b0, 0, 1'b0);
    fetch(32'h02C, 1'b0, 0, 1'b0);
    fetch(32'h000, 1'b0, 0, 1'b0);
    check("stats_model_miss", 32'(m_miss), 32'd3);
    check_stats("stats");

    // Randomized fetches over a small set of lines to mix hits and conflicts.
    for (int n = 0; n < 150; n++) begin
      int sel, ia;
      bit isame, istray;
      sel = int'($urandom_range(0, 4));
      a = (sel == 4) ? 32'hFFFF_FF00 : (32'(sel) << 8);
      a = a | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      lat = int'($urandom_range(1, 3));
      isame = ($urandom_range(0, 15) == 0);
      istray = ($urandom_range(0, 3) == 0);
      ia = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, LINE_WORDS * lat + 1)) : 0;
      if ($urandom_range(0, 19) == 0) inval_idle();
      fetch(a, isame, ia, istray);
    end
    check_stats("final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped, read-only instruction cache sitting directly upstream of the core control unit. It answers the control unit's one-cycle `icache_req` fetch pulse with an instruction word and a one-cycle `icache_ready` pulse. On a miss it refills a whole line from external memory over a simple req/ack word interface.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 32: byte-address width of `pc` and `mem_addr`.
- `LINE_WORDS`, default 4: 32-bit words per line (power of two, ≥2).
- `NUM_LINES`, default 16: number of lines (power of two, ≥2).

**Ports** (clock and reset first)
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `icache_req` in 1: fetch request, one-cycle pulse from the control unit.
- `pc` in ADDR_WIDTH: fetch byte address; stable from `icache_req` until `icache_ready`; bits [1:0] ignored.
- `icache_ready` out 1: one-cycle pulse, `icache_instr` valid.
- `icache_instr` out 32: fetched instruction; holds its value until the next response.
- `invalidate` in 1: clears all valid bits (fence.i).
- `mem_req` out 1: refill word request.
- `mem_addr` out ADDR_WIDTH: word-aligned refill address.
- `mem_ack` in 1: one-cycle pulse, `mem_rdata` valid.
- `mem_rdata` in 32: refill data.
- `hit_count` out 32: hit counter (see Configuration).
- `miss_count` out 32: miss counter (see Configuration).

## Operation

**Address split**
- Word offset = `pc[2+OB-1:2]`, where OB = log2(LINE_WORDS).
- Index = next log2(NUM_LINES) bits.
- Tag = remaining upper bits.

**Storage**
- Register arrays: `valid[NUM_LINES]`, `tag[NUM_LINES]`, `data[NUM_LINES][LINE_WORDS]`.
- Lookup is combinational.

**FSM states**
- IDLE
  - `icache_req` and hit (valid and tag match): latch the word into `icache_instr`, raise `icache_ready` next cycle, stay in IDLE.
  - `icache_req` and miss: latch `pc`, clear word counter, go to REFILL.
  - `icache_req` is ignored outside IDLE.
- REFILL
  - `mem_req`=1, `mem_addr` = line base + 4·counter.
  - Each `mem_ack`: write `mem_rdata` into the data array and increment the counter. `mem_addr` advances the cycle after the ack; `mem_req` stays high between words.
  - On the ack of word LINE_WORDS−1: write tag, set valid (unless an invalidate is pending), drop `mem_req`, go to RESPOND.
- RESPOND
  - Drive the requested word from the data array into `icache_instr`, pulse `icache_ready`, go to IDLE.

**Invalidate**
- In IDLE: clears all valid bits at that edge.
- Same edge as `icache_req`: the invalidate takes effect first, so the request is treated as a miss.
- In REFILL or RESPOND: sets a pending flag. The line completing refill is written but left invalid. All valid bits are cleared on entry to IDLE, and the flag clears.

**Reset (asserted at any time, including mid-refill)**
- FSM goes to IDLE.
- All valid bits and the counter clear.
- `mem_req`=0, `icache_ready`=0, `icache_instr`=0, counters=0.
- An abandoned memory transaction is simply dropped; any late `mem_ack` in IDLE is ignored.

## Timing

- Hit: `icache_req` sampled at edge N → `icache_ready`=1 for cycle N..N+1. The control unit, then in its wait state, samples it at edge N+1.
- Miss: `mem_req` rises after edge N. With memory ack latency L cycles per word, `icache_ready` pulses 1 cycle after the last ack edge. Minimum miss latency (L=1) = LINE_WORDS+2 cycles from the request edge.
- `icache_ready` is never high for two consecutive cycles.
- `mem_addr` is stable whenever `mem_req`=1 and no ack has been seen for the current word.
- All outputs are registered except `mem_addr`, which is derived from the latched line base and the counter.

## Configuration

- Macro: `ICACHE_STATS_EN`.
- Defined: `hit_count` increments on each hit-path response and `miss_count` on each REFILL entry. Both are 32-bit, wrap modulo 2^32, and clear on reset.
- Undefined: both outputs are constant 0 and no counter logic is synthesised. Cache behaviour is otherwise identical.

## Test plan

- **Cold miss:** reset; req `pc`=0x100; memory returns 0xA0..0xA3 with L=1 → `mem_addr` 0x100,0x104,0x108,0x10C; `icache_ready` 6 cycles after the req edge; `icache_instr`=0xA0.
- **Hit:** after the above, req `pc`=0x108 → `icache_ready` next cycle, `icache_instr`=0xA2, `mem_req` stays 0.
- **Conflict:** req 0x100, then 0x500 (same index, LINE_WORDS=4, NUM_LINES=16) → both miss. A repeat of 0x100 misses again.
- **Invalidate during refill:** `invalidate` pulse mid-REFILL → response delivered correctly; the next req to the same line misses.
- **Reset mid-refill:** `reset` low after the second ack → `mem_req`=0 immediately; a later req to that line misses; with the macro defined, `miss_count` restarts from 0.
- **Stats:** with `ICACHE_STATS_EN`, 3 misses + 5 hits → `miss_count`=3, `hit_count`=5. Without the macro, both read 0.
